// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares the write port of the
// asynchronous FIFO among NUM_REQ requesters, in the FIFO write clock domain.
// Each grant covers a burst of up to MAX_BURST beats. Every beat is gated on
// fifo_full, so a word is only accepted when the FIFO can take it on the
// same edge.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clka,
  input  logic                            rsta,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy,
  output logic [CNT_WIDTH-1:0]            xfer_count
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [0:0]        ST_IDLE   = 1'b0;
  localparam logic [0:0]        ST_GRANT  = 1'b1;
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W-1:0]   ID_ZERO   = ID_W'(0);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
  localparam logic [BEAT_W-1:0] BEAT_ZERO = BEAT_W'(0);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [0:0]           state_r;
  logic [ID_W-1:0]      grant_id_r;
  logic [ID_W-1:0]      last_grant_r;
  logic [BEAT_W-1:0]    beat_cnt_r;
  logic [CNT_WIDTH-1:0] xfer_count_r;

  logic [ID_W-1:0]       base_s;
  logic                  pick_found_s;
  logic [ID_W-1:0]       pick_id_s;
  logic                  in_grant_s;
  logic                  grant_valid_s;
  logic [DATA_WIDTH-1:0] grant_data_s;
  logic                  xfer_s;
  logic                  final_beat_s;
  logic                  release_s;

  // Round-robin search starting just after 'base'; 'base' itself is checked
  // last. Returns {found, index}.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    base);
    logic            found;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx;
    int              pos;
    found = 1'b0;
    win   = ID_ZERO;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = (int'(base) + k) % NUM_REQ;
      idx = ID_W'(pos);
      if (!found && valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end else begin
        win   = win;
      end
    end
    return {found, win};
  endfunction

  // Arbitration and handshake terms: in IDLE the search starts after the last
  // grant; in GRANT it starts after the current holder so it re-picks last.
  always_comb begin
    in_grant_s    = (state_r == ST_GRANT);
    if (in_grant_s) begin
      base_s = grant_id_r;
    end else begin
      base_s = last_grant_r;
    end
    {pick_found_s, pick_id_s} = rr_pick(req_valid, base_s);
    grant_valid_s = req_valid[grant_id_r];
    grant_data_s  = req_data[grant_id_r*DATA_WIDTH +: DATA_WIDTH];
    xfer_s        = in_grant_s && grant_valid_s && !fifo_full;
    final_beat_s  = xfer_s && (beat_cnt_r == LAST_BEAT);
    release_s     = in_grant_s && (final_beat_s || !grant_valid_s);
  end

  // Zero-latency write path: the granted requester drives the FIFO directly.
  always_comb begin
    req_ready    = {NUM_REQ{1'b0}};
    fifo_wr_en   = 1'b0;
    fifo_data_in = {DATA_WIDTH{1'b0}};
    if (in_grant_s) begin
      req_ready[grant_id_r] = !fifo_full;
      fifo_wr_en            = xfer_s;
      fifo_data_in          = grant_data_s;
    end else begin
      req_ready    = {NUM_REQ{1'b0}};
      fifo_wr_en   = 1'b0;
      fifo_data_in = {DATA_WIDTH{1'b0}};
    end
  end

  // Grant FSM: IDLE arbitrates in one cycle; GRANT hands over on release
  // without a bubble when another (or the same) requester is waiting.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_r      <= ST_IDLE;
      grant_id_r   <= ID_ZERO;
      last_grant_r <= LAST_ID;
      beat_cnt_r   <= BEAT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            state_r    <= ST_GRANT;
            grant_id_r <= pick_id_s;
            beat_cnt_r <= BEAT_ZERO;
          end
        end
        ST_GRANT: begin
          if (release_s) begin
            last_grant_r <= grant_id_r;
            beat_cnt_r   <= BEAT_ZERO;
            if (pick_found_s) begin
              grant_id_r <= pick_id_s;
            end else begin
              state_r <= ST_IDLE;
            end
          end else if (xfer_s) begin
            beat_cnt_r <= beat_cnt_r + BEAT_ONE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          beat_cnt_r <= BEAT_ZERO;
        end
      endcase
    end
  end

  // Running count of accepted words; wraps naturally at its width.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      xfer_count_r <= CNT_ZERO;
    end else if (xfer_s) begin
      xfer_count_r <= xfer_count_r + CNT_ONE;
    end
  end

  assign grant_id   = grant_id_r;
  assign busy       = in_grant_s;
  assign xfer_count = xfer_count_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: randomized and directed requester traffic,
// checked every cycle against a behavioural round-robin model, plus literal
// expectations on write order and timing for the directed scenarios.
module tb_fifo_wr_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic            clka = 1'b0;
  logic            rsta;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic            fifo_full;

  logic [NR-1:0]   req_ready,  req_ready4;
  logic            fifo_wr_en, wr_en4;
  logic [DW-1:0]   fifo_data_in, data4;
  logic [1:0]      grant_id,   grant4;
  logic            busy,       busy4;
  logic [15:0]     xfer_count;
  logic [3:0]      xfer_count4;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MAXB), .CNT_WIDTH(16)) dut (
    .clka(clka), .rsta(rsta), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_data_in(fifo_data_in), .grant_id(grant_id), .busy(busy),
    .xfer_count(xfer_count));

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MAXB), .CNT_WIDTH(4)) dut4 (
    .clka(clka), .rsta(rsta), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready4), .fifo_full(fifo_full), .fifo_wr_en(wr_en4),
    .fifo_data_in(data4), .grant_id(grant4), .busy(busy4),
    .xfer_count(xfer_count4));

  initial forever #5 clka = ~clka;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clka) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Word n of requester i: requester in the high nibble offset, index low.
  function automatic logic [7:0] data_of(input int i, input int n);
    int v;
    v = 160 + i * 16 + n;
    return v[7:0];
  endfunction

  // ---------------- behavioural model ----------------
  bit m_busy;
  int m_g, m_last, m_beats, m_cnt;

  function automatic int rr_next(input int from, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      if (v[(from + k) % NR]) return (from + k) % NR;
    end
    return -1;
  endfunction

  int         log_cyc[$];
  logic [7:0] log_dat[$];

  // Compare process: check every output against the model, then advance it.
  always @(negedge clka) begin
    logic [NR-1:0] e_ready;
    logic          e_wr;
    logic [7:0]    e_data;
    int            w;
    if (rsta) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_data", fifo_data_in, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_count", xfer_count, 0);
      m_busy = 0; m_g = 0; m_last = NR - 1; m_beats = 0; m_cnt = 0;
    end else begin
      e_ready = (m_busy && !fifo_full) ? (4'b0001 << m_g) : 4'b0000;
      e_wr    = m_busy && req_valid[m_g] && !fifo_full;
      e_data  = m_busy ? req_data[m_g*DW +: DW] : 8'h00;
      chk("ready", req_ready, e_ready);
      chk("wr_en", fifo_wr_en, e_wr);
      chk("data", fifo_data_in, e_data);
      chk("grant_id", grant_id, m_g);
      chk("busy", busy, m_busy);
      chk("count", xfer_count, m_cnt % 65536);
      chk("w4_wr_en", wr_en4, e_wr);
      chk("w4_ready", req_ready4, e_ready);
      chk("w4_count", xfer_count4, m_cnt % 16);
      if (fifo_wr_en === 1'b1) begin
        log_cyc.push_back(cyc);
        log_dat.push_back(fifo_data_in);
      end
      if (!m_busy) begin
        w = rr_next(m_last, req_valid);
        if (w >= 0) begin m_busy = 1; m_g = w; m_beats = 0; end
      end else begin
        if (req_valid[m_g] && !fifo_full) begin m_cnt++; m_beats++; end
        if (!req_valid[m_g] || m_beats == MAXB) begin
          m_last = m_g;
          w = rr_next(m_g, req_valid);
          if (w >= 0) begin m_g = w; m_beats = 0; end
          else m_busy = 0;
        end
      end
    end
  end

  // ---------------- requester / FIFO driver ----------------
  int budget[NR], sent[NR], start[NR], gap_after[NR];
  int p_valid, p_drop, p_full;
  int full_at, full_len, full_left, total_acc;
  logic [NR-1:0] acc;

  task automatic drive_step(input int it);
    logic [NR-1:0] nv;
    bit pend;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        sent[i]++; total_acc++;
        if (total_acc == full_at) full_left = full_len;
      end
    end
    for (int i = 0; i < NR; i++) begin
      pend = (sent[i] < budget[i]) && (it >= start[i]);
      if (!pend) nv[i] = 1'b0;
      else if (acc[i] && sent[i] == gap_after[i]) nv[i] = 1'b0;
      else if (req_valid[i] && !acc[i]) nv[i] = ($urandom_range(99) >= p_drop);
      else nv[i] = ($urandom_range(99) < p_valid);
      req_data[i*DW +: DW] = data_of(i, sent[i]);
    end
    req_valid = nv;
    if (full_left > 0) begin fifo_full = 1'b1; full_left--; end
    else fifo_full = ($urandom_range(99) < p_full);
  endtask

  task automatic run_phase(input int n);
    for (int it = 0; it < n; it++) begin
      @(negedge clka);
      acc = req_valid & req_ready;
      @(posedge clka);
      #1;
      drive_step(it);
    end
  endtask

  task automatic new_test();
    @(posedge clka); #1;
    rsta = 1'b1; req_valid = '0; fifo_full = 1'b0; acc = '0;
    for (int i = 0; i < NR; i++) begin
      budget[i] = 0; sent[i] = 0; start[i] = 0; gap_after[i] = -1;
      req_data[i*DW +: DW] = data_of(i, 0);
    end
    p_valid = 100; p_drop = 0; p_full = 0;
    full_at = -1; full_len = 0; full_left = 0; total_acc = 0;
    repeat (2) @(posedge clka);
    #2 rsta = 1'b0;
    log_cyc.delete(); log_dat.delete();
  endtask

  task automatic chk_log(input string nm, input logic [7:0] exp[$]);
    chk({nm, "_nwrites"}, log_dat.size(), exp.size());
    for (int k = 0; k < exp.size() && k < log_dat.size(); k++)
      chk({nm, "_word"}, log_dat[k], exp[k]);
  endtask

  logic [7:0] exp_q[$];
  int t_valid;

  initial begin
    rsta = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0; acc = '0;

    // T1: single requester streams six words; re-granted to itself, no bubble.
    new_test();
    chk("reset_busy", busy, 0);
    chk("reset_grant", grant_id, 0);
    budget[0] = 6;
    t_valid = cyc + 1;
    run_phase(12);
    exp_q.delete();
    for (int n = 0; n < 6; n++) exp_q.push_back(data_of(0, n));
    chk_log("t1", exp_q);
    chk("t1_first_write_latency", log_cyc.size() > 0 ? log_cyc[0] - t_valid : -1, 1);
    chk("t1_span", log_cyc.size() == 6 ? log_cyc[5] - log_cyc[0] : -1, 5);
    chk("t1_count", xfer_count, 6);
    chk("t1_model_count", m_cnt, 6);

    // T2: all four continuously valid with 8 words each.
    new_test();
    for (int i = 0; i < NR; i++) budget[i] = 8;
    run_phase(40);
    exp_q.delete();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NR; i++)
        for (int n = 0; n < 4; n++) exp_q.push_back(data_of(i, 4 * b + n));
    chk_log("t2", exp_q);
    chk("t2_span", log_cyc.size() == 32 ? log_cyc[31] - log_cyc[0] : -1, 31);
    chk("t2_count", xfer_count, 32);
    chk("t2_count4", xfer_count4, 0);

    // T3: FIFO full for three cycles after beat 2 of requester 1.
    new_test();
    budget[1] = 4; full_at = 2; full_len = 3;
    run_phase(14);
    exp_q.delete();
    for (int n = 0; n < 4; n++) exp_q.push_back(data_of(1, n));
    chk_log("t3", exp_q);
    chk("t3_gap_full", log_cyc.size() == 4 ? log_cyc[2] - log_cyc[1] : -1, 4);
    chk("t3_gap_after", log_cyc.size() == 4 ? log_cyc[3] - log_cyc[2] : -1, 1);
    chk("t3_idle_after", busy, 0);

    // T4: requester 2 drops valid after two beats; 3 then 0 go before it again.
    new_test();
    budget[2] = 4; gap_after[2] = 2;
    budget[3] = 4;
    budget[0] = 4; start[0] = 2;
    run_phase(20);
    exp_q.delete();
    exp_q.push_back(data_of(2, 0)); exp_q.push_back(data_of(2, 1));
    for (int n = 0; n < 4; n++) exp_q.push_back(data_of(3, n));
    for (int n = 0; n < 4; n++) exp_q.push_back(data_of(0, n));
    exp_q.push_back(data_of(2, 2)); exp_q.push_back(data_of(2, 3));
    chk_log("t4", exp_q);
    chk("t4_drop_gap", log_cyc.size() >= 3 ? log_cyc[2] - log_cyc[1] : -1, 2);

    // T5: asynchronous reset mid-burst, between clock edges.
    new_test();
    for (int i = 0; i < NR; i++) begin budget[i] = 12; start[i] = i; end
    run_phase(7);
    chk("t5_busy_before", busy, 1);
    #1 rsta = 1'b1;
    #1;
    chk("t5_async_ready", req_ready, 0);
    chk("t5_async_wr_en", fifo_wr_en, 0);
    chk("t5_async_data", fifo_data_in, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_count", xfer_count, 0);
    @(posedge clka); #2 rsta = 1'b0;
    log_cyc.delete(); log_dat.delete();
    run_phase(12);
    chk("t5_first_after_reset", log_dat.size() > 0 ? (log_dat[0] - 8'hA0) >> 4 : 8'hFF, 0);

    // T6: 17 words; the 4-bit counter wraps to 1.
    new_test();
    budget[0] = 17;
    run_phase(25);
    chk("t6_nwrites", log_dat.size(), 17);
    chk("t6_span", log_cyc.size() == 17 ? log_cyc[16] - log_cyc[0] : -1, 16);
    chk("t6_count", xfer_count, 17);
    chk("t6_count4", xfer_count4, 1);

    // T7: randomized valids, drops and full, checked by the model each cycle.
    for (int r = 0; r < 3; r++) begin
      new_test();
      for (int i = 0; i < NR; i++) begin
        budget[i] = $urandom_range(40); start[i] = $urandom_range(20);
      end
      p_valid = 40 + 20 * r; p_drop = 10 - 5 * r; p_full = 30 - 10 * r;
      run_phase(400);
      chk("t7_count_vs_log", xfer_count, log_dat.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter for the asynchronous FIFO. Shares the FIFO write side among NUM_REQ requesters.
- Runs entirely in the FIFO write clock domain.
- Drives the FIFO's wr_en/data_in from the winning requester and grants each requester a burst of up to MAX_BURST beats.
- Gates every transfer on the FIFO's full flag, so no write is ever dropped.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 8, FIFO word width; must match the FIFO.
- MAX_BURST, 4, maximum beats per grant (>=1).
- CNT_WIDTH, 16, width of the total-transfer counter.

Ports:
- clka  in  1  write-domain clock.
- rsta  in  1  reset: asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester word-available flag.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept (combinational).
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write enable (combinational).
- fifo_data_in  out  DATA_WIDTH  FIFO write data (combinational).
- grant_id  out  $clog2(NUM_REQ)  currently granted requester index.
- busy  out  1  high while in GRANT state.
- xfer_count  out  CNT_WIDTH  total accepted words since reset; wraps.

Behaviour:
- States: IDLE and GRANT. Registered state:
  - state
  - grant_id
  - last_grant (reset NUM_REQ-1, so requester 0 has first priority)
  - beat_cnt (0..MAX_BURST-1)
  - xfer_count
- Reset (async, takes effect immediately, independent of clka):
  - state=IDLE, grant_id=0, beat_cnt=0, xfer_count=0, last_grant=NUM_REQ-1.
  - Consequently req_ready=0, fifo_wr_en=0, fifo_data_in=0, busy=0.
  - A burst in progress is abandoned. No partial write is issued during reset.
- Round-robin pick: search indices last_grant+1, +2, … wrapping modulo NUM_REQ. First index with req_valid=1 wins; last_grant itself has lowest priority.
- IDLE:
  - No ready, no wr_en.
  - If any req_valid: grant_id<=pick, state<=GRANT, beat_cnt<=0.
  - Arbitration costs exactly 1 cycle from IDLE.
- GRANT (g = grant_id):
  - req_ready[g] = !fifo_full. All other req_ready = 0.
  - xfer = req_valid[g] && !fifo_full.
  - fifo_wr_en = xfer. fifo_data_in = req_data[g] while in GRANT, 0 in IDLE.
  - Zero latency: the word is written to the FIFO on the same clka edge it is accepted.
  - On xfer: xfer_count += 1 (wraps modulo 2^CNT_WIDTH) and beat_cnt += 1.
- Release conditions, evaluated each GRANT cycle:
  - (a) xfer && beat_cnt==MAX_BURST-1 (final beat), or
  - (b) req_valid[g]==0 (no transfer that cycle).
- On release:
  - last_grant<=g.
  - Re-pick in the same cycle, with g at lowest priority. For (a), the pick uses current valids with g's valid counted.
  - If a winner exists: grant_id<=winner, beat_cnt<=0, stay in GRANT. Back-to-back bursts have no bubble.
  - Otherwise: state<=IDLE, grant_id holds its value.
- fifo_full in GRANT:
  - Grant is held, ready=0, no write, beat_cnt frozen. No timeout.
  - If valid drops while full, release (b) applies.
- Requester protocol: hold valid and data stable until ready. If valid drops without a transfer, the arbiter releases and does not flag an error.
- Single requester valid continuously: re-granted to itself every MAX_BURST beats with no idle cycle.
- busy = (state==GRANT).

Test Plan:
- Reset, then req0 streams 0xA0..0xA5 (MAX_BURST=4), others idle → grant_id=0 one cycle after valid. Six consecutive fifo_wr_en pulses with data A0..A5 in order, no bubble after beat 4. xfer_count=6.
- All 4 requesters continuously valid, 8 words each → grant order 0,1,2,3,0,1,2,3, each burst 4 writes. fifo_wr_en high every cycle after the first arbitration cycle. xfer_count=32.
- req1 granted, fifo_full high after beat 2 for 3 cycles → req_ready[1]=0 and fifo_wr_en=0 for those 3 cycles, grant_id stays 1. Beats 3–4 complete after full drops, then release.
- req2 drops valid after 2 beats while req3 valid → the next cycle grant_id=3 with no IDLE cycle. req2 gets its next grant only after req3 and req0 (if valid).
- rsta pulsed asynchronously mid-burst between clka edges → req_ready, fifo_wr_en, fifo_data_in, busy, xfer_count read 0 before the next edge. After release with all valid, requester 0 is granted first.
- CNT_WIDTH=4, 17 accepted words → xfer_count=1. No extra or missing fifo_wr_en pulses.
